// File: rtl/z80_block_cp_sequencer.sv
// z80_block_cp_sequencer: sequences CPI/CPD/CPIR/CPDR (read at HL, extended T-cycles, optional repeat penalty)
// Optional abort input when Z80_BLOCK_CP_ABORT_EN is defined.
module z80_block_cp_sequencer #(
  parameter int EXT_CYCLES = 5,
  parameter int REP_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_dec,
  input  logic        op_rep,
  input  logic [7:0]  reg_a_in,
  input  logic [7:0]  reg_f_in,
  input  logic [15:0] reg_bc_in,
  input  logic [15:0] reg_hl_in,
  input  logic [15:0] reg_ip_in,
`ifdef Z80_BLOCK_CP_ABORT_EN
  input  logic        abort,
`endif
  output logic        mem_rd_req,
  output logic [15:0] mem_raddr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  reg_f_out,
  output logic [15:0] reg_bc_out,
  output logic [15:0] reg_hl_out,
  output logic [15:0] reg_ip_out
);
  typedef enum logic [2:0] {IDLE, READ, EXT, REP, DONE} state_t;
  state_t      state;
  logic [7:0]  a_r, f_r, res_f, d;
  logic [15:0] bc_r, hl_r, ip_r, res_bc, res_hl, res_ip, bc_m1;
  logic        dec_r, rep_r, take_r, z, v, h, abort_i;
  logic [3:0]  cnt;
`ifdef Z80_BLOCK_CP_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif
  assign d     = a_r - mem_rdata;
  assign bc_m1 = bc_r - 16'd1;
  assign z     = (d == 8'd0);
  assign v     = (bc_m1 != 16'd0);
  assign h     = (a_r[3:0] < mem_rdata[3:0]);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_raddr  <= '0;
      reg_f_out  <= '0;
      reg_bc_out <= '0;
      reg_hl_out <= '0;
      reg_ip_out <= '0;
      a_r        <= '0;
      f_r        <= '0;
      bc_r       <= '0;
      hl_r       <= '0;
      ip_r       <= '0;
      dec_r      <= 1'b0;
      rep_r      <= 1'b0;
      take_r     <= 1'b0;
      cnt        <= '0;
      res_f      <= '0;
      res_bc     <= '0;
      res_hl     <= '0;
      res_ip     <= '0;
    end else if (abort_i && (state == READ || state == EXT || state == REP)) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mem_rd_req <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r        <= reg_a_in;
          f_r        <= reg_f_in;
          bc_r       <= reg_bc_in;
          hl_r       <= reg_hl_in;
          ip_r       <= reg_ip_in;
          dec_r      <= op_dec;
          rep_r      <= op_rep;
          mem_raddr  <= reg_hl_in;
          mem_rd_req <= 1'b1;
          busy       <= 1'b1;
          state      <= READ;
        end
        READ: if (mem_rd_ack) begin
          mem_rd_req <= 1'b0;
          res_f      <= {d[7], z, f_r[5], h, f_r[3], v, 1'b1, f_r[0]};
          res_bc     <= bc_m1;
          res_hl     <= dec_r ? hl_r - 16'd1 : hl_r + 16'd1;
          take_r     <= rep_r && v && !z;
          res_ip     <= (rep_r && v && !z) ? ip_r : ip_r + 16'd2;
          cnt        <= '0;
          state      <= EXT;
        end
        EXT: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(EXT_CYCLES - 1)) begin
            cnt        <= '0;
            state      <= take_r ? REP : DONE;
            done       <= !take_r;
            reg_f_out  <= take_r ? reg_f_out : res_f;
            reg_bc_out <= take_r ? reg_bc_out : res_bc;
            reg_hl_out <= take_r ? reg_hl_out : res_hl;
            reg_ip_out <= take_r ? reg_ip_out : res_ip;
          end
        end
        REP: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(REP_CYCLES - 1)) begin
            cnt        <= '0;
            state      <= DONE;
            done       <= 1'b1;
            reg_f_out  <= res_f;
            reg_bc_out <= res_bc;
            reg_hl_out <= res_hl;
            reg_ip_out <= res_ip;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
